// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and op codes for the bit-serial adder/subtractor
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: single combinational full-adder bit, the only arithmetic in the datapath
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: LSB-first bit-serial add/subtract through one full-adder cell with valid/ready on both sides
module serial_add_sub
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
   logic [CW-1:0] cnt;
   logic carry, cout_r, ovf_r, fa_s, fa_co, last;
   full_adder_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .cin(carry),
      .s  (fa_s),
      .co (fa_co)
   );
   assign last = (cnt == LAST);
   assign sum  = sum_sh;
   assign cout = cout_r;
   assign ovf  = ovf_r;
   // next state, handshake flags and the sum register's shifted-in value
   always_comb begin
      state_nxt = IDLE;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      sum_nxt   = sum_sh >> 1;
      sum_nxt[WIDTH-1] = fa_s;
      case (state)
         IDLE:    state_nxt = in_valid ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   // state register; async reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   // operand load on accept, then one bit per cycle; subtract folds into inverted b and carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_sh  <= a;
         b_sh  <= (sub == OP_SUB) ? ~b : b;
         carry <= (sub == OP_SUB) ? ~cin : cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         sum_sh <= sum_nxt;
         carry  <= fa_co;
         cnt    <= last ? cnt : cnt + CW'(1);
         if (last) begin
            cout_r <= fa_co;
            ovf_r  <= carry ^ fa_co;
         end
      end
   end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed checks of serial_add_sub at WIDTH=8 and WIDTH=1
module tb_serial_add_sub;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, out_valid, out_ready = 1'b0, cout, ovf;
   logic [7:0] a = '0, b = '0, sum;
   logic v1 = 1'b0, r1, c1 = 1'b0, s1 = 1'b0, ov1, or1 = 1'b0, co1, ovf1;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   serial_add_sub #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf)
   );
   serial_add_sub #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
      .cin(c1), .sub(s1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
      .cout(co1), .ovf(ovf1)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // reference: true integer result of the operation, reduced to w bits, plus borrow/carry and signed range test
   function automatic void model(input int w, input int ua, input int ub, input int ci, input int sb,
                                 output int es, output int ec, output int eo);
      int m, r, sa, sbv, sr;
      m   = 1 << w;
      r   = sb ? ua - ub - ci : ua + ub + ci;
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      sr  = sb ? sa - sbv - ci : sa + sbv + ci;
      es  = (r + 2 * m) % m;
      ec  = sb ? int'(r >= 0) : int'(r >= m);
      eo  = int'(sr >= m / 2 || sr < -(m / 2));
   endfunction
   task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic si, input int hold);
      int lat, es, ec, eo;
      model(8, int'(ai), int'(bi), int'(ci), int'(si), es, ec, eo);
      check("idle_ready", in_ready, 1);
      in_valid = 1'b1; a = ai; b = bi; cin = ci; sub = si;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 8);
      check("sum", sum, es);
      check("cout", cout, ec);
      check("ovf", ovf, eo);
      check("busy_ready", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_sum", sum, es);
         check("hold_cout", cout, ec);
         check("hold_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
      check("idle_sum_held", sum, es);
   endtask
   initial begin
      int es, ec, eo;
      #12;
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_valid", out_valid, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", in_ready, 1);
      do_op(8'h3C, 8'h5A, 1'b0, 1'b0, 0);
      check("plan1_sum", sum, 8'h96);
      check("plan1_ovf", ovf, 1);
      do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1);
      check("plan2_cout", cout, 1);
      do_op(8'h10, 8'h20, 1'b0, 1'b1, 5);
      check("plan3_sum", sum, 8'hF0);
      check("plan3_cout", cout, 0);
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrun_rst_valid", out_valid, 0);
      check("midrun_rst_sum", sum, 0);
      check("midrun_rst_cout", cout, 0);
      check("midrun_rst_ovf", ovf, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrun_ready", in_ready, 1);
      do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);
      check("after_rst_sum", sum, 8'h02);
      for (int i = 0; i < 40; i++)
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      for (int i = 0; i < 16; i++) begin
         model(1, i & 1, (i >> 1) & 1, (i >> 2) & 1, (i >> 3) & 1, es, ec, eo);
         check("w1_ready", r1, 1);
         v1 = 1'b1; a1 = 1'(i); b1 = 1'(i >> 1); c1 = 1'(i >> 2); s1 = 1'(i >> 3);
         @(posedge clk); #1 v1 = 1'b0;
         check("w1_run", ov1, 0);
         @(posedge clk); #1;
         check("w1_valid", ov1, 1);
         check("w1_sum", sum1, es);
         check("w1_cout", co1, ec);
         check("w1_ovf", ovf1, eo);
         or1 = 1'b1;
         @(posedge clk); #1 or1 = 1'b0;
         check("w1_release", ov1, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
